// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG scan master: TAP-shadow states,
// op encodings and the length of the post-reset TLR->RTI walk.
package jtag_pkg;

  typedef enum logic [2:0] {
    ST_RTI     = 3'd0,
    ST_SEL_DR  = 3'd1,
    ST_SEL_IR  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_EXIT1   = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } tap_state_e;

  localparam logic OP_DR = 1'b0;
  localparam logic OP_IR = 1'b1;

  // Five TMS=1 edges reach Test-Logic-Reset from anywhere, one TMS=0 edge lands in RTI.
  localparam int RST_SEQ_LEN = 6;

endpackage

// File: rtl/jtag_scan_master_if.sv
// Host-side request/response bundle of the JTAG scan master.
interface jtag_scan_master_if #(
  parameter int DR_MAX = 211
);
  localparam int LEN_W = $clog2(DR_MAX + 1);

  logic              start;
  logic              op;
  logic [LEN_W-1:0]  len;
  logic [DR_MAX-1:0] din;
  logic [DR_MAX-1:0] dout;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output start, op, len, din, input dout, busy, done, err);
  modport slave  (input start, op, len, din, output dout, busy, done, err);
endinterface

// File: rtl/jtag_tck_gen.sv
// TCLK divider: one TCLK half-period per TCK_DIV CK cycles while en is high;
// rise/fall are one-CK strobes in the cycle before TCLK changes.
module jtag_tck_gen #(
  parameter int TCK_DIV = 5
) (
  input  logic CK,
  input  logic TRST,
  input  logic en,
  output logic tclk,
  output logic rise,
  output logic fall
);
  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CNT_MAX);
  assign rise = wrap && !tclk;
  assign fall = wrap &&  tclk;

  // Dropping en parks TCLK low and restarts the half-period from zero.
  always_ff @(posedge CK or negedge TRST) begin
    if (!TRST) begin
      cnt  <= '0;
      tclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      tclk <= ~tclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs one DR or IR scan per accepted start through a TAP-shadow FSM.
// Optional JTAG_MASTER_RESET_SEQ_EN walks the target TAP to RTI after TRST release.
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int IR_W    = 2,
  parameter int DR_MAX  = 211,
  parameter int TCK_DIV = 5
) (
  input  logic              CK,
  input  logic              TRST,
  jtag_scan_master_if.slave req,
  output logic              TCLK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);
  localparam int LEN_W = $clog2(DR_MAX + 1);

`ifdef JTAG_MASTER_RESET_SEQ_EN
  localparam logic SEQ_AT_RESET = 1'b1;
`else
  localparam logic SEQ_AT_RESET = 1'b0;
`endif

  tap_state_e        state;
  logic              busy, done, err;
  logic              tms, tdi;
  logic              is_ir;
  logic [LEN_W-1:0]  nbits, bit_cnt;
  logic [DR_MAX-1:0] din_q, dout_q;
  logic              seq, seq_pend;
  logic [2:0]        seq_cnt;

  logic rise, fall, tck_en;
  logic accept, bad_len, last_bit;

  assign tck_en   = busy && (state != ST_DONE);
  assign accept   = req.start && !busy && !done;
  assign bad_len  = (req.op == OP_DR) &&
                    ((req.len == '0) || (req.len > LEN_W'(DR_MAX)));
  assign last_bit = (bit_cnt == nbits - 1'b1);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .CK   (CK),
    .TRST (TRST),
    .en   (tck_en),
    .tclk (TCLK),
    .rise (rise),
    .fall (fall)
  );

  assign TMS      = tms;
  assign TDI      = tdi;
  assign req.dout = dout_q;
  assign req.busy = busy;
  assign req.done = done;
  assign req.err  = err;

  always_ff @(posedge CK or negedge TRST) begin
    if (!TRST) begin
      state    <= ST_RTI;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      is_ir    <= 1'b0;
      nbits    <= '0;
      bit_cnt  <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      seq      <= 1'b0;
      seq_pend <= SEQ_AT_RESET;
      seq_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (seq_pend) begin
        seq_pend <= 1'b0;
        seq      <= 1'b1;
        busy     <= 1'b1;
        seq_cnt  <= '0;
      end else if (!busy) begin
        if (accept && bad_len) begin
          done <= 1'b1;
          err  <= 1'b1;
        end else if (accept) begin
          busy    <= 1'b1;
          is_ir   <= req.op;
          nbits   <= (req.op == OP_IR) ? LEN_W'(IR_W) : req.len;
          bit_cnt <= '0;
          din_q   <= req.din;
          dout_q  <= '0;
          tms     <= 1'b1;
        end
      end else if (state == ST_DONE) begin
        // Target already sits in RTI; a reset walk finishes silently.
        busy  <= 1'b0;
        state <= ST_RTI;
        tms   <= 1'b1;
        tdi   <= 1'b0;
        seq   <= 1'b0;
        done  <= !seq;
      end else if (rise) begin
        case (state)
          ST_RTI: begin
            if (seq) begin
              seq_cnt <= seq_cnt + 1'b1;
              if (seq_cnt == 3'(RST_SEQ_LEN - 1)) state <= ST_DONE;
            end else begin
              state <= ST_SEL_DR;
            end
          end
          ST_SEL_DR:  state <= tms ? ST_SEL_IR : ST_CAPTURE;
          ST_SEL_IR:  state <= ST_CAPTURE;
          ST_CAPTURE: state <= ST_SHIFT;
          ST_SHIFT: begin
            dout_q[bit_cnt] <= TDO;
            bit_cnt         <= bit_cnt + 1'b1;
            if (tms) state <= ST_EXIT1;
          end
          ST_EXIT1:   state <= ST_UPDATE;
          ST_UPDATE:  state <= ST_DONE;
          default:    state <= ST_RTI;
        endcase
      end else if (fall) begin
        // TMS/TDI set here are what the target samples on the next rising edge.
        tdi <= 1'b0;
        case (state)
          ST_RTI:    tms <= seq ? (seq_cnt < 3'(RST_SEQ_LEN - 1)) : 1'b1;
          ST_SEL_DR: tms <= is_ir;
          ST_SHIFT: begin
            tdi <= din_q[bit_cnt];
            tms <= last_bit;
          end
          ST_EXIT1:  tms <= 1'b1;
          default:   tms <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP target plus a scoreboard of expected
// dout/err per request, popped when done pulses.
module tb_jtag_scan_master;
  localparam int IR_W    = 2;
  localparam int DR_MAX  = 211;
  localparam int TCK_DIV = 5;
  localparam int LEN_W   = $clog2(DR_MAX + 1);
  localparam int BUDGET  = 2 * TCK_DIV * (DR_MAX + 8) + 40;

  logic CK = 1'b0;
  logic TRST = 1'b0;
  logic TCLK, TMS, TDI, TDO;

  jtag_scan_master_if #(.DR_MAX(DR_MAX)) bus();

  jtag_scan_master #(.IR_W(IR_W), .DR_MAX(DR_MAX), .TCK_DIV(TCK_DIV)) dut (
    .CK(CK), .TRST(TRST), .req(bus.slave),
    .TCLK(TCLK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CK = ~CK;

  // ---------------- target TAP model ----------------
  typedef enum int {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR, T_UPDR,
                    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR} tap_t;
  tap_t              ts;
  logic [DR_MAX-1:0] chain, dr_upd;
  logic [IR_W-1:0]   ir_sh, ir;
  logic              tap_load = 1'b0;
  tap_t              load_st;
  logic [DR_MAX-1:0] load_chain;

  always @(posedge TCLK or posedge tap_load) begin
    if (tap_load) begin
      ts    <= load_st;
      chain <= load_chain;
    end else begin
      case (ts)
        T_TLR:   ts <= TMS ? T_TLR   : T_RTI;
        T_RTI:   ts <= TMS ? T_SELDR : T_RTI;
        T_SELDR: ts <= TMS ? T_SELIR : T_CAPDR;
        T_CAPDR: ts <= TMS ? T_EX1DR : T_SHDR;
        T_SHDR: begin chain <= {TDI, chain[DR_MAX-1:1]}; ts <= TMS ? T_EX1DR : T_SHDR; end
        T_EX1DR: ts <= TMS ? T_UPDR  : T_PDR;
        T_PDR:   ts <= TMS ? T_EX2DR : T_PDR;
        T_EX2DR: ts <= TMS ? T_UPDR  : T_SHDR;
        T_UPDR:  begin dr_upd <= chain; ts <= TMS ? T_SELDR : T_RTI; end
        T_SELIR: ts <= TMS ? T_TLR   : T_CAPIR;
        T_CAPIR: begin ir_sh <= IR_W'(1); ts <= TMS ? T_EX1IR : T_SHIR; end
        T_SHIR:  begin ir_sh <= {TDI, ir_sh[IR_W-1:1]}; ts <= TMS ? T_EX1IR : T_SHIR; end
        T_EX1IR: ts <= TMS ? T_UPIR  : T_PIR;
        T_PIR:   ts <= TMS ? T_EX2IR : T_PIR;
        T_EX2IR: ts <= TMS ? T_UPIR  : T_SHIR;
        T_UPIR:  begin ir <= ir_sh; ts <= TMS ? T_SELDR : T_RTI; end
        default: ts <= T_TLR;
      endcase
    end
  end

  assign TDO = (ts == T_SHDR) ? chain[0] : (ts == T_SHIR) ? ir_sh[0] : 1'b0;

  // ---------------- observation ----------------
  int  rise_cnt = 0;
  int  done_cnt = 0;
  time last_rise_t = 0;

  always @(posedge TCLK) begin
    rise_cnt    <= rise_cnt + 1;
    last_rise_t <= $time;
  end
  always @(negedge CK) if (bus.done) done_cnt <= done_cnt + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DR_MAX-1:0] dout;
    logic              err;
  } exp_t;
  exp_t              sb[$];
  logic [DR_MAX-1:0] exp_chain;
  logic [DR_MAX-1:0] last_dout;
  int                n_chk = 0;
  int                n_pass = 0;

  function automatic logic [DR_MAX-1:0] rand_vec();
    logic [223:0] t;
    t = '0;
    for (int i = 0; i < 7; i++) t = {t[191:0], 32'($urandom)};
    return t[DR_MAX-1:0];
  endfunction

  task automatic load_tap(input tap_t s, input logic [DR_MAX-1:0] c);
    load_st    = s;
    load_chain = c;
    exp_chain  = c;
    tap_load   = 1'b1;
    #1 tap_load = 1'b0;
  endtask

  task automatic drive_start(input logic o, input int l, input logic [DR_MAX-1:0] d);
    @(negedge CK);
    bus.op    = o;
    bus.len   = LEN_W'(l);
    bus.din   = d;
    bus.start = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (bus.done) begin ok = 1'b1; break; end
      @(negedge CK);
    end
  endtask

  // Pushes the target's expected response, starts the scan, waits for done.
  task automatic do_scan(input logic o, input int l, input logic [DR_MAX-1:0] d, output bit ok);
    exp_t e;
    e.err  = 1'b0;
    e.dout = '0;
    if (o) e.dout[IR_W-1:0] = IR_W'(1);
    else begin
      for (int k = 0; k < l; k++) begin
        e.dout[k] = exp_chain[0];
        exp_chain = {d[k], exp_chain[DR_MAX-1:1]};
      end
    end
    sb.push_back(e);
    drive_start(o, l, d);
    wait_done(ok);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0; bus.op = 1'b0; bus.len = '0; bus.din = '0;
    TRST = 1'b0;
`ifdef JTAG_MASTER_RESET_SEQ_EN
    load_tap(T_SHDR, '0);
`else
    load_tap(T_RTI, '0);
`endif
    repeat (3) @(negedge CK);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else n_pass++;
    n_chk++; if (bus.err  !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err); else n_pass++;
    n_chk++; if (TCLK !== 1'b0) $display("FAIL reset_tclk got %b exp 0", TCLK); else n_pass++;
    n_chk++; if (TMS  !== 1'b1) $display("FAIL reset_tms got %b exp 1", TMS); else n_pass++;
    n_chk++; if (TDI  !== 1'b0) $display("FAIL reset_tdi got %b exp 0", TDI); else n_pass++;
    n_chk++; if (bus.dout !== '0) $display("FAIL reset_dout got %h exp 0", bus.dout); else n_pass++;
    last_dout = '0;
    TRST = 1'b1;
  endtask

`ifdef JTAG_MASTER_RESET_SEQ_EN
  task automatic test_reset_seq();
    int r0, d0;
    bit ok;
    r0 = rise_cnt; d0 = done_cnt;
    repeat (2) @(negedge CK);
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL seq_busy got %b exp 1", bus.busy); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CK);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge CK);
    n_chk++; if (!ok) $display("FAIL seq_timeout busy still %b", bus.busy); else n_pass++;
    n_chk++; if (rise_cnt - r0 !== 6) $display("FAIL seq_edges got %0d exp 6", rise_cnt - r0); else n_pass++;
    n_chk++; if (ts !== T_RTI) $display("FAIL seq_tap_state got %0d exp %0d", ts, T_RTI); else n_pass++;
    n_chk++; if (done_cnt !== d0) $display("FAIL seq_done got %0d pulses exp 0", done_cnt - d0); else n_pass++;
    n_chk++; if (TCLK !== 1'b0) $display("FAIL seq_tclk_idle got %b exp 0", TCLK); else n_pass++;
  endtask
`else
  task automatic test_idle_after_reset();
    repeat (4) @(negedge CK);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", bus.busy); else n_pass++;
  endtask
`endif

  task automatic test_ir_scan();
    int r0;
    bit ok;
    exp_t e;
    r0 = rise_cnt;
    do_scan(1'b1, 0, DR_MAX'(2'b11), ok);
    e = sb.pop_front();
    n_chk++; if (!ok) $display("FAIL ir_timeout no done within %0d cycles", BUDGET); else n_pass++;
    n_chk++; if ($time - last_rise_t !== 15) $display("FAIL ir_done_latency got %0t exp 15", $time - last_rise_t); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL ir_busy_at_done got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.err !== e.err) $display("FAIL ir_err got %b exp %b", bus.err, e.err); else n_pass++;
    n_chk++; if (bus.dout !== e.dout) $display("FAIL ir_dout got %h exp %h", bus.dout, e.dout); else n_pass++;
    n_chk++; if (rise_cnt - r0 !== IR_W + 6) $display("FAIL ir_edges got %0d exp %0d", rise_cnt - r0, IR_W + 6); else n_pass++;
    n_chk++; if (ir !== 2'b11) $display("FAIL ir_model_ir got %b exp 11", ir); else n_pass++;
    n_chk++; if (ts !== T_RTI) $display("FAIL ir_tap_state got %0d exp %0d", ts, T_RTI); else n_pass++;
    last_dout = e.dout;
  endtask

  task automatic test_dr_full();
    int r0;
    bit ok;
    exp_t e;
    logic [DR_MAX-1:0] d;
    d = DR_MAX'(32'hdeadbeef);
    @(negedge CK);
    load_tap(T_RTI, '0);
    r0 = rise_cnt;
    do_scan(1'b0, DR_MAX, d, ok);
    e = sb.pop_front();
    n_chk++; if (!ok) $display("FAIL full_timeout no done"); else n_pass++;
    n_chk++; if (bus.dout !== e.dout) $display("FAIL full_dout got %h exp %h", bus.dout, e.dout); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL full_err got %b exp 0", bus.err); else n_pass++;
    n_chk++; if (rise_cnt - r0 !== DR_MAX + 5) $display("FAIL full_edges got %0d exp %0d", rise_cnt - r0, DR_MAX + 5); else n_pass++;
    n_chk++; if (chain !== d) $display("FAIL full_chain got %h exp %h", chain, d); else n_pass++;
    n_chk++; if (dr_upd !== d) $display("FAIL full_update got %h exp %h", dr_upd, d); else n_pass++;
    last_dout = e.dout;
  endtask

  task automatic test_dr_patterns();
    int lens[4] = '{1, 2, 36, 210};
    foreach (lens[i]) begin
      int r0;
      bit ok;
      exp_t e;
      logic [DR_MAX-1:0] d;
      d = rand_vec();
      @(negedge CK);
      load_tap(T_RTI, rand_vec());
      r0 = rise_cnt;
      do_scan(1'b0, lens[i], d, ok);
      e = sb.pop_front();
      n_chk++; if (!ok) $display("FAIL pat%0d_timeout no done", lens[i]); else n_pass++;
      n_chk++; if (bus.dout !== e.dout) $display("FAIL pat%0d_dout got %h exp %h", lens[i], bus.dout, e.dout); else n_pass++;
      n_chk++; if (rise_cnt - r0 !== lens[i] + 5) $display("FAIL pat%0d_edges got %0d exp %0d", lens[i], rise_cnt - r0, lens[i] + 5); else n_pass++;
      n_chk++; if (chain !== exp_chain) $display("FAIL pat%0d_chain got %h exp %h", lens[i], chain, exp_chain); else n_pass++;
      repeat (7) @(negedge CK);
      n_chk++; if (bus.dout !== e.dout) $display("FAIL pat%0d_dout_hold got %h exp %h", lens[i], bus.dout, e.dout); else n_pass++;
      last_dout = e.dout;
    end
  endtask

  task automatic test_len_err();
    int bad[2] = '{0, DR_MAX + 1};
    foreach (bad[i]) begin
      int r0;
      exp_t e;
      e.dout = last_dout;
      e.err  = 1'b1;
      sb.push_back(e);
      r0 = rise_cnt;
      drive_start(1'b0, bad[i], rand_vec());
      e = sb.pop_front();
      n_chk++; if (bus.done !== 1'b1) $display("FAIL err%0d_done got %b exp 1", bad[i], bus.done); else n_pass++;
      n_chk++; if (bus.err !== e.err) $display("FAIL err%0d_err got %b exp %b", bad[i], bus.err, e.err); else n_pass++;
      n_chk++; if (bus.dout !== e.dout) $display("FAIL err%0d_dout got %h exp %h", bad[i], bus.dout, e.dout); else n_pass++;
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL err%0d_busy got %b exp 0", bad[i], bus.busy); else n_pass++;
      repeat (3 * TCK_DIV) @(negedge CK);
      n_chk++; if (rise_cnt !== r0 || TCLK !== 1'b0) $display("FAIL err%0d_tclk edges %0d tclk %b exp 0 0", bad[i], rise_cnt - r0, TCLK); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int r0, d0;
    bit ok;
    exp_t e;
    logic [DR_MAX-1:0] d;
    d = rand_vec();
    @(negedge CK);
    load_tap(T_RTI, rand_vec());
    r0 = rise_cnt; d0 = done_cnt;
    fork
      do_scan(1'b0, 36, d, ok);
      begin
        repeat (3) begin
          repeat (50) @(negedge CK);
          bus.op = 1'b1; bus.len = LEN_W'(5); bus.din = rand_vec(); bus.start = 1'b1;
          @(negedge CK);
          bus.start = 1'b0;
        end
      end
    join
    e = sb.pop_front();
    n_chk++; if (!ok) $display("FAIL b2b_timeout no done"); else n_pass++;
    n_chk++; if (bus.dout !== e.dout) $display("FAIL b2b_dout got %h exp %h", bus.dout, e.dout); else n_pass++;
    // a start coinciding with done must also be dropped
    bus.op = 1'b0; bus.len = LEN_W'(8); bus.start = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
    repeat (4 * TCK_DIV * 10) @(negedge CK);
    n_chk++; if (done_cnt - d0 !== 1) $display("FAIL b2b_done_count got %0d exp 1", done_cnt - d0); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (rise_cnt - r0 !== 41) $display("FAIL b2b_edges got %0d exp 41", rise_cnt - r0); else n_pass++;
    n_chk++; if (chain !== exp_chain) $display("FAIL b2b_chain got %h exp %h", chain, exp_chain); else n_pass++;
    last_dout = e.dout;
  endtask

  task automatic test_trst_abort();
    int r0, d0;
    bit ok;
    exp_t e;
    logic [DR_MAX-1:0] d;
    @(negedge CK);
    load_tap(T_RTI, rand_vec());
    r0 = rise_cnt; d0 = done_cnt;
    drive_start(1'b0, 200, rand_vec());
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (rise_cnt - r0 == 103) begin ok = 1'b1; break; end
      @(negedge CK);
    end
    n_chk++; if (!ok) $display("FAIL trst_reach_bit100 edges %0d exp 103", rise_cnt - r0); else n_pass++;
    TRST = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL trst_status busy/done/err got %b%b%b exp 000", bus.busy, bus.done, bus.err); else n_pass++;
    n_chk++; if (TCLK !== 1'b0 || TMS !== 1'b1 || TDI !== 1'b0)
      $display("FAIL trst_pins tclk/tms/tdi got %b%b%b exp 010", TCLK, TMS, TDI); else n_pass++;
    n_chk++; if (bus.dout !== '0) $display("FAIL trst_dout got %h exp 0", bus.dout); else n_pass++;
    repeat (3) @(negedge CK);
    TRST = 1'b1;
    repeat (40) @(negedge CK);
    n_chk++; if (done_cnt !== d0) $display("FAIL trst_no_done got %0d pulses exp 0", done_cnt - d0); else n_pass++;
    last_dout = '0;
`ifdef JTAG_MASTER_RESET_SEQ_EN
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (!bus.busy) begin ok = 1'b1; break; end
      @(negedge CK);
    end
`endif
    // target state is unknown after the abort; put the model back in RTI
    load_tap(T_RTI, rand_vec());
    d = rand_vec();
    r0 = rise_cnt;
    do_scan(1'b0, 8, d, ok);
    e = sb.pop_front();
    n_chk++; if (!ok) $display("FAIL post_trst_timeout no done"); else n_pass++;
    n_chk++; if (bus.dout !== e.dout) $display("FAIL post_trst_dout got %h exp %h", bus.dout, e.dout); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL post_trst_err got %b exp 0", bus.err); else n_pass++;
    n_chk++; if (rise_cnt - r0 !== 13) $display("FAIL post_trst_edges got %0d exp 13", rise_cnt - r0); else n_pass++;
    n_chk++; if (chain !== exp_chain) $display("FAIL post_trst_chain got %h exp %h", chain, exp_chain); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef JTAG_MASTER_RESET_SEQ_EN
    test_reset_seq();
`else
    test_idle_after_reset();
`endif
    test_ir_scan();
    test_dr_full();
    test_dr_patterns();
    test_len_err();
    test_back_to_back();
    test_trst_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 Parameter IR_W, default 2: instruction register length in bits.
REQ-002 Parameter DR_MAX, default 211: maximum data register length; sizes din/dout.
REQ-003 Parameter TCK_DIV, default 5: CK cycles per TCLK half-period; minimum 1.
REQ-004 CK  input  1  system clock; all state updates on its rising edge.
REQ-005 TRST  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-CK request pulse; sampled only when busy=0.
REQ-007 op  input  1  0 = DR scan, 1 = IR scan.
REQ-008 len  input  $clog2(DR_MAX+1)  bits to shift; IR scans use IR_W and ignore len.
REQ-009 din  input  DR_MAX  shift-in vector; bit 0 is shifted first.
REQ-010 dout  output  DR_MAX  captured TDO bits; bit i is the i-th bit shifted out.
REQ-011 busy  output  1  high from the CK after an accepted start until done.
REQ-012 done  output  1  one-CK completion pulse.
REQ-013 err  output  1  qualifies done; high for a rejected request.
REQ-014 TCLK, TMS, TDI  output  1 each  JTAG drive to the target TAP.
REQ-015 TDO  input  1  JTAG return from the target.

Function
REQ-016 SHALL hold a TAP-shadow FSM: RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, DONE.
REQ-017 SHALL generate TCLK only while busy; TCLK idles low, period 2*TCK_DIV CK cycles.
REQ-018 SHALL change TMS/TDI only on TCLK falling strobes and sample TDO only on TCLK rising strobes.
REQ-019 DR scan SHALL issue TMS 1,0,0, then len shift edges (TMS=0, last edge TMS=1), then 1,0: len+5 rising edges total.
REQ-020 IR scan SHALL issue TMS 1,1,0,0, then IR_W shift edges (last TMS=1), then 1,0: IR_W+6 rising edges total.
REQ-021 TDI SHALL present din[k] before the k-th shift rising edge; TDO sampled at that edge goes to dout[k].
REQ-022 dout bits at or above len SHALL be 0; dout stays stable from done until the next accepted start.
REQ-023 done SHALL pulse one CK after the final RTI rising edge; busy falls in the same cycle.
REQ-024 len=0 or len>DR_MAX on a DR scan SHALL produce done=1, err=1 on the next CK, with no TCLK activity.
REQ-025 start while busy=1 SHALL be ignored; start coinciding with done SHALL be ignored.
REQ-026 TDI SHALL be 0 outside SHIFT.

Reset
REQ-027 TRST low SHALL asynchronously force: FSM=RTI, TCLK=0, TMS=1, TDI=0, busy=0, done=0, err=0, dout=0, divider=0.
REQ-028 TRST asserted mid-scan SHALL abort with no done pulse; the target TAP state is then undefined until a reset sequence runs.

Configuration
REQ-029 With JTAG_MASTER_RESET_SEQ_EN defined, after TRST release the master SHALL hold busy=1 and drive 5 TCLK edges with TMS=1, then 1 edge with TMS=0 (Test-Logic-Reset to RTI), then deassert busy without pulsing done.
REQ-030 Without JTAG_MASTER_RESET_SEQ_EN, busy=0 immediately after reset and the target is assumed to be in RTI.

Structure
REQ-031 Package jtag_pkg SHALL hold the TAP-shadow state enum, the op encodings (OP_DR, OP_IR), and the reset-sequence length constant.
REQ-032 Sub-module jtag_tck_gen SHALL implement the TCK_DIV divider and emit one-CK rise and fall strobes plus TCLK.

Verification
REQ-033 IR_W=2, op=1, din=2'b11, TAP model -> 8 TCLK rising edges, model IR=2'b11, done after the last edge, err=0.
REQ-034 DR_MAX=211, len=211, din=211'hdeadbeef, model loops TDI to TDO through a 211-bit chain preloaded to 0 -> dout=0, model chain holds 211'hdeadbeef after Update.
REQ-035 len=0, then len=212 -> each gives done=1, err=1 within 1 CK, TCLK stays 0.
REQ-036 start pulsed 3 times during a len=36 scan -> exactly one done, dout matches a single 36-bit scan.
REQ-037 TRST low at shift bit 100 -> all outputs at reset values within the same CK, no done; a following len=8 scan completes correctly.
REQ-038 With JTAG_MASTER_RESET_SEQ_EN, model TAP starting in Shift-DR -> model in RTI after 6 edges, busy low, no done pulse.
